// File: rtl/hdmi_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Definitions shared by the HDMI data-island blocks.
//   - Widths of the packet header and subpackets.
//   - Length of a data-island packet slot, in pixels.
//   - InfoFrame / data-packet type codes (header byte 0).
//   - The null-packet header, and a bundle struct holding one packet.
// Contains no ports; blocks pull it in with import hdmi_pkg::*.
// ---------------------------------------------------------------------------
package hdmi_pkg;

    localparam int HDR_W      = 24;
    localparam int SUB_W      = 56;
    localparam int NUM_SUB    = 4;
    localparam int SLOT_LEN   = 32;
    localparam int SLOT_CNT_W = 5;

    // Packet type codes (header byte 0)
    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_GCP          = 8'h03;
    localparam logic [7:0] PKT_AVI_IF       = 8'h82;
    localparam logic [7:0] PKT_SPD_IF       = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    // HB2/HB1 zero, HB0 = null type code; the whole header reads 24'h000000
    localparam logic [HDR_W-1:0] NULL_HEADER = {16'h0000, PKT_NULL};

    typedef logic [NUM_SUB-1:0][SUB_W-1:0] sub_bundle_t;

    typedef struct packed {
        logic [HDR_W-1:0] header;
        sub_bundle_t      sub;
    } pkt_bundle_t;

    function automatic pkt_bundle_t null_packet();
        pkt_bundle_t p;
        p.header = NULL_HEADER;
        p.sub    = '0;
        return p;
    endfunction

    // True on the last pixel of a packet slot
    function automatic logic is_last_pixel(input logic [SLOT_CNT_W-1:0] cnt);
        return cnt == SLOT_CNT_W'(SLOT_LEN - 1);
    endfunction

endpackage

// File: rtl/packet_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selection among packet sources.
// The search starts at index ptr and walks upward, wrapping modulo NUM_SRC.
// With PACKET_SCHEDULER_AUDIO_PRIORITY_EN defined, source 0 wins outright
// whenever it is eligible, and it is skipped during the round-robin walk.
// Ports:
//   elig   in   NUM_SRC  eligible sources
//   ptr    in   IDX_W    round-robin start index
//   valid  out  1        some source is eligible
//   winner out  IDX_W    selected source index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_SRC-1:0] rr_elig;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        return IDX_W'((int'(base) + offs) % NUM_SRC);
    endfunction

    always_comb begin
        rr_elig = elig;
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
        rr_elig[0] = 1'b0;
`endif
        valid  = 1'b0;
        winner = '0;
        // Walk from farthest to nearest so the nearest eligible index is
        // written last and wins, without needing an early exit.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rr_elig[wrap_idx(ptr, k)]) begin
                valid  = 1'b1;
                winner = wrap_idx(ptr, k);
            end
        end
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
        if (elig[0]) begin
            valid  = 1'b1;
            winner = '0;
        end
`endif
    end

endmodule

// File: rtl/packet_scheduler.sv
// ---------------------------------------------------------------------------
// packet_scheduler
// Picks which requester's packet goes into each 32-pixel data-island slot
// and holds that packet's header/subpackets steady for the packet assembler.
//
// Optional feature: define PACKET_SCHEDULER_AUDIO_PRIORITY_EN to give
// source 0 (audio samples) strict priority over the round-robin sources.
//
// Ports:
//   clk_pixel           in   1              pixel clock
//   reset               in   1              synchronous, active-high
//   data_island_period  in   1              high during packet slots
//   frame_start         in   1              one-cycle pulse per video frame
//   src_req             in   NUM_SRC        per-source packet request
//   src_header          in   NUM_SRC x 24   per-source header
//   src_sub             in   NUM_SRC x 4x56 per-source subpackets
//   src_grant           out  NUM_SRC        one-hot packet-committed pulse
//   header              out  24             header to assembler
//   sub                 out  4 x 56         subpackets to assembler
//   slot_counter        out  5              pixel position inside the slot
// ---------------------------------------------------------------------------
import hdmi_pkg::*;

module packet_scheduler #(
    parameter int NUM_SRC            = 4,
    parameter int ONCE_PER_FRAME_SRC = NUM_SRC - 1
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          data_island_period,
    input  logic                          frame_start,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0][23:0]      src_header,
    input  logic [NUM_SRC-1:0][3:0][55:0] src_sub,
    output logic [NUM_SRC-1:0]            src_grant,
    output logic [23:0]                   header,
    output logic [3:0][55:0]              sub,
    output logic [4:0]                    slot_counter
);

    localparam int               IDX_W    = $clog2(NUM_SRC);
    localparam logic [IDX_W-1:0] ONCE_IDX = IDX_W'(ONCE_PER_FRAME_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   held_src;
    logic               held_vld;
    logic [IDX_W-1:0]   win_src;
    logic               win_vld;
    logic               frame_pend;
    logic [NUM_SRC-1:0] elig;
    logic               reload;
    logic               commit;
    pkt_bundle_t        win_pkt;
    pkt_bundle_t        pkt_q;

    // The InfoFrame source may only go once per frame
    always_comb begin
        elig = src_req;
        elig[ONCE_PER_FRAME_SRC] = src_req[ONCE_PER_FRAME_SRC] & frame_pend;
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .elig   (elig),
        .ptr    (ptr),
        .valid  (win_vld),
        .winner (win_src)
    );

    always_comb begin
        win_pkt = null_packet();
        if (win_vld) begin
            win_pkt.header = src_header[win_src];
            win_pkt.sub    = src_sub[win_src];
        end
    end

    // Outside an island the bundle tracks the live winner every cycle; inside
    // it only changes on the last pixel, setting up the next slot.
    assign reload = !data_island_period || is_last_pixel(slot_counter);

    // The packet in hand is committed on the first pixel of its slot. The
    // grant follows the held bundle, not src_req, so a source that withdrew
    // after being loaded is still sent and granted.
    assign commit = !reset && data_island_period && (slot_counter == '0) && held_vld;

    always_comb begin
        src_grant = '0;
        if (commit) src_grant[held_src] = 1'b1;
    end

    assign ptr_next = (held_src == LAST_IDX) ? '0 : held_src + 1'b1;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            slot_counter <= '0;
            pkt_q        <= null_packet();
            held_vld     <= 1'b0;
            held_src     <= '0;
            ptr          <= '0;
            frame_pend   <= 1'b0;
        end else begin
            if (data_island_period) slot_counter <= slot_counter + 1'b1;

            if (reload) begin
                pkt_q    <= win_pkt;
                held_vld <= win_vld;
                held_src <= win_src;
            end

            if (commit) begin
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
                // Audio wins by priority, so it must not disturb the rotation
                if (held_src != '0) ptr <= ptr_next;
`else
                ptr <= ptr_next;
`endif
            end

            // A new frame re-arms the InfoFrame even if it is granted this cycle
            if (frame_start)
                frame_pend <= 1'b1;
            else if (commit && held_src == ONCE_IDX)
                frame_pend <= 1'b0;
        end
    end

    assign header = pkt_q.header;
    assign sub    = pkt_q.sub;

endmodule

// File: tb/tb_packet_scheduler.sv
module tb_packet_scheduler;

    localparam int NUM_SRC = 4;
    localparam int ONCE    = NUM_SRC - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          reset       = 1'b1;
    logic                          dip         = 1'b0;
    logic                          frame_start = 1'b0;
    logic [NUM_SRC-1:0]            src_req     = '0;
    logic [NUM_SRC-1:0][23:0]      src_header  = '0;
    logic [NUM_SRC-1:0][3:0][55:0] src_sub     = '0;
    logic [NUM_SRC-1:0]            src_grant;
    logic [23:0]                   header;
    logic [3:0][55:0]              sub;
    logic [4:0]                    slot_counter;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    packet_scheduler #(.NUM_SRC(NUM_SRC), .ONCE_PER_FRAME_SRC(ONCE)) dut (
        .clk_pixel          (clk),
        .reset              (reset),
        .data_island_period (dip),
        .frame_start        (frame_start),
        .src_req            (src_req),
        .src_header         (src_header),
        .src_sub            (src_sub),
        .src_grant          (src_grant),
        .header             (header),
        .sub                (sub),
        .slot_counter       (slot_counter)
    );

    task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_held is the source whose packet sits in the output bundle, -1 = null.
    int               m_slot = 0;
    int               m_held = -1;
    int               m_ptr  = 0;
    bit               m_pend = 1'b0;
    logic [23:0]      m_hdr  = '0;
    logic [3:0][55:0] m_sub  = '0;

    function automatic int pick(input logic [NUM_SRC-1:0] req, input bit pend, input int ptr);
        logic [NUM_SRC-1:0] e;
        e = req;
        if (!pend) e[ONCE] = 1'b0;
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
        if (e[0]) return 0;
        e[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_SRC; k++)
            if (e[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        bit g;
        if (reset) begin
            m_slot <= 0; m_held <= -1; m_ptr <= 0; m_pend <= 1'b0;
            m_hdr  <= '0; m_sub <= '0;
        end else begin
            g = dip && m_slot == 0 && m_held >= 0;
            w = pick(src_req, m_pend, m_ptr);
            if (dip) m_slot <= (m_slot + 1) % 32;
            if (!dip || m_slot == 31) begin
                m_held <= w;
                if (w >= 0) begin m_hdr <= src_header[w]; m_sub <= src_sub[w]; end
                else        begin m_hdr <= '0;            m_sub <= '0;          end
            end
            if (g) begin
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
                if (m_held != 0) m_ptr <= (m_held + 1) % NUM_SRC;
`else
                m_ptr <= (m_held + 1) % NUM_SRC;
`endif
            end
            if (frame_start)             m_pend <= 1'b1;
            else if (g && m_held == ONCE) m_pend <= 1'b0;
        end
    end

    // ---------------- compare process + grant log ----------------
    int          gl_src[$];
    int          gl_slot[$];
    logic [23:0] gl_hdr[$];

    always @(negedge clk) if (chk_en) begin
        logic [NUM_SRC-1:0] eg;
        eg = '0;
        if (!reset && dip && m_slot == 0 && m_held >= 0) eg[m_held] = 1'b1;
        chk("slot_counter", 224'(slot_counter), 224'(m_slot));
        chk("src_grant",    224'(src_grant),    224'(eg));
        chk("header",       224'(header),       224'(m_hdr));
        chk("sub",          sub,                m_sub);
        for (int i = 0; i < NUM_SRC; i++) if (src_grant[i]) begin
            gl_src.push_back(i);
            gl_slot.push_back(int'(slot_counter));
            gl_hdr.push_back(header);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; advances n cycles. With drop set, a granted
    // requester releases its request, as a real source would.
    task automatic cyc(input int n, input bit drop);
        logic [NUM_SRC-1:0] g;
        repeat (n) begin
            @(negedge clk);
            g = src_grant;
            @(posedge clk);
            #1;
            if (drop) src_req = src_req & ~g;
            frame_start = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; dip = 1'b0; frame_start = 1'b0; src_req = '0;
        cyc(2, 1'b0);
        reset = 1'b0;
        gl_src.delete(); gl_slot.delete(); gl_hdr.delete();
    endtask

    task automatic new_bundle(input int i);
        src_header[i] = 24'($urandom);
        for (int j = 0; j < 4; j++) src_sub[i][j] = 56'({$urandom, $urandom});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_left;
        int exp_d[5];

        for (int i = 0; i < NUM_SRC; i++) new_bundle(i);

        // Reset state
        do_reset();
        chk_en = 1'b1;
        chk("rst_slot",   224'(slot_counter), 224'(0));
        chk("rst_header", 224'(header),       224'(0));
        chk("rst_grant",  224'(src_grant),    224'(0));

        // No requests over two island slots: nothing granted, null header
        dip = 1'b1;
        cyc(64, 1'b1);
        dip = 1'b0;
        chk("idle_grants", 224'(gl_src.size()), 224'(0));
        chk("idle_header", 224'(header),        224'(0));

        // src1 and src2 requesting over three slots
        do_reset();
        src_req = 4'b0110;
        cyc(4, 1'b1);
        dip = 1'b1;
        cyc(96, 1'b1);
        dip = 1'b0;
        cyc(2, 1'b1);
        chk("two_src_count", 224'(gl_src.size()), 224'(2));
        if (gl_src.size() == 2) begin
            chk("two_src_first",  224'(gl_src[0]),  224'(1));
            chk("two_src_second", 224'(gl_src[1]),  224'(2));
            chk("two_src_slot0",  224'(gl_slot[0]), 224'(0));
            chk("two_src_slot1",  224'(gl_slot[1]), 224'(0));
        end

        // InfoFrame source granted once per frame even if it keeps requesting
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) new_bundle(i);
        frame_start = 1'b1;
        cyc(1, 1'b0);
        src_req = 4'b1000;
        cyc(3, 1'b0);
        dip = 1'b1;
        cyc(128, 1'b0);
        dip = 1'b0;
        cyc(1, 1'b0);
        chk("once_count", 224'(gl_src.size()), 224'(1));
        if (gl_src.size() == 1) begin
            chk("once_src", 224'(gl_src[0]), 224'(3));
            chk("once_hdr", 224'(gl_hdr[0]), 224'(src_header[3]));
        end

        // All sources requesting continuously for five slots
        do_reset();
        frame_start = 1'b1;
        src_req = '1;
        cyc(2, 1'b0);
        dip = 1'b1;
        cyc(160, 1'b0);
        dip = 1'b0;
        cyc(1, 1'b0);
`ifdef PACKET_SCHEDULER_AUDIO_PRIORITY_EN
        exp_d = '{0, 0, 0, 0, 0};
`else
        exp_d = '{0, 1, 2, 3, 0};
`endif
        chk("all_count", 224'(gl_src.size()), 224'(5));
        if (gl_src.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("all_order%0d", i), 224'(gl_src[i]), 224'(exp_d[i]));

        // Reset in the middle of a slot
        do_reset();
        src_req = 4'b0011;
        cyc(2, 1'b0);
        dip = 1'b1;
        cyc(40, 1'b0);
        for (int k = 0; k < 64 && slot_counter != 5'd17; k++) cyc(1, 1'b0);
        chk("mid_reach17", 224'(slot_counter), 224'(17));
        reset = 1'b1;
        cyc(1, 1'b0);
        reset = 1'b0;
        chk("mid_slot",   224'(slot_counter), 224'(0));
        chk("mid_header", 224'(header),       224'(0));
        chk("mid_grant",  224'(src_grant),    224'(0));
        gl_src.delete(); gl_slot.delete(); gl_hdr.delete();
        cyc(64, 1'b0);
        dip = 1'b0;
        chk("mid_count", 224'(gl_src.size()), 224'(1));
        if (gl_src.size() == 1) chk("mid_restart_src0", 224'(gl_src[0]), 224'(0));

        // Held winner withdraws right after being loaded: still sent and granted
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) new_bundle(i);
        cyc(2, 1'b0);
        dip = 1'b1;
        cyc(10, 1'b0);
        src_req = 4'b0010;
        cyc(1, 1'b0);
        for (int k = 0; k < 64 && slot_counter != 5'd0; k++) cyc(1, 1'b0);
        chk("wd_reach0", 224'(slot_counter), 224'(0));
        src_req = '0;
        cyc(40, 1'b0);
        dip = 1'b0;
        chk("wd_count", 224'(gl_src.size()), 224'(1));
        if (gl_src.size() == 1) begin
            chk("wd_src", 224'(gl_src[0]), 224'(1));
            chk("wd_hdr", 224'(gl_hdr[0]), 224'(src_header[1]));
        end

        // Randomised traffic against the model
        do_reset();
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                dip = ~dip;
                if (dip) run_left = 32 * $urandom_range(1, 3);
                else     run_left = $urandom_range(1, 20);
                if ($urandom_range(0, 7) == 0) run_left = $urandom_range(1, 40);
            end
            run_left--;
            frame_start = ($urandom_range(0, 199) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_req[i] && $urandom_range(0, 15) == 0) begin
                    new_bundle(i);
                    src_req[i] = 1'b1;
                end else if (src_req[i] && $urandom_range(0, 299) == 0) begin
                    src_req[i] = 1'b0;
                end
            end
            cyc(1, 1'b1);
        end
        reset = 1'b0;
        dip   = 1'b0;
        cyc(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
